mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter_io_decode.sv | 13 +
 rtl/mem_arbiter.sv | 81 ++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CPU/host RAM arbiter: FSM states,
// PIA register map and the default host-grant spacing.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam logic [15:0] PIA_KBD   = 16'hD010;
  localparam logic [15:0] PIA_KBDCR = 16'hD011;
  localparam logic [15:0] PIA_DSP   = 16'hD012;
  localparam logic [15:0] PIA_DSPCR = 16'hD013;

  localparam int HOST_GAP_DEF = 4;

  // Widened by one bit so a window placed at the top of memory cannot wrap.
  function automatic logic in_io_window(input logic [15:0] addr, input logic [15:0] base);
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} <= ({1'b0, base} + 17'd3));
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, host, RAM and PIA signals around the arbiter.
// slave = arbiter side, master = surrounding system side.
interface mem_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic        rdy_in;
  logic        cpu_halt;
  logic        cpu_rdy;
  logic [7:0]  cpu_di;

  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic        io_req;
  logic        io_we;
  logic [7:0]  io_rdata;

  modport slave (
    input  cpu_addr, cpu_do, cpu_we, rdy_in, cpu_halt,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata, io_rdata,
    output cpu_rdy, cpu_di, host_ack, host_rdata,
    output mem_addr, mem_wdata, mem_we, io_req, io_we
  );

  modport master (
    output cpu_addr, cpu_do, cpu_we, rdy_in, cpu_halt,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata, io_rdata,
    input  cpu_rdy, cpu_di, host_ack, host_rdata,
    input  mem_addr, mem_wdata, mem_we, io_req, io_we
  );
endinterface

// File: rtl/mem_arbiter_io_decode.sv
// Combinational decode of the four-register PIA window on the CPU address.
module mem_arbiter_io_decode
  import mem_arbiter_pkg::*;
#(
  parameter logic [15:0] IO_BASE = PIA_KBD
) (
  input  logic [15:0] addr,
  output logic        io_hit
);

  assign io_hit = in_io_window(addr, IO_BASE);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: the CPU owns RAM in IDLE; a host access steals
// two cycles (GRANT, RESP), with a programmable idle gap between grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [15:0] IO_BASE  = PIA_KBD,
  parameter int          HOST_GAP = HOST_GAP_DEF
) (
  input  logic          clk_dut,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] GAP_LOAD = 3'(HOST_GAP);

  arb_state_t state;
  arb_state_t state_nxt;
  logic [2:0] gap_cnt;
  logic       io_sel_q;
  logic       io_hit;

  mem_arbiter_io_decode #(
    .IO_BASE (IO_BASE)
  ) u_io_decode (
    .addr   (bus.cpu_addr),
    .io_hit (io_hit)
  );

  always_ff @(posedge clk_dut or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gap_cnt  <= 3'd0;
      io_sel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          io_sel_q <= io_hit;
          if (gap_cnt != 3'd0) gap_cnt <= gap_cnt - 3'd1;
        end
        RESP:    gap_cnt <= GAP_LOAD;
        default: ;
      endcase
    end
  end

  // A halted CPU cannot be starved, so the gap only protects a running CPU.
  always_comb begin
    state_nxt     = state;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_do;
    bus.mem_we    = 1'b0;
    bus.host_ack  = 1'b0;
    bus.cpu_rdy   = 1'b0;
    bus.io_req    = 1'b0;
    case (state)
      IDLE: begin
        bus.mem_we  = bus.cpu_we & ~io_hit;
        bus.cpu_rdy = bus.rdy_in;
        bus.io_req  = io_hit;
        if (bus.host_req && ((gap_cnt == 3'd0) || bus.cpu_halt)) state_nxt = GRANT;
      end
      GRANT: begin
        bus.mem_addr  = bus.host_addr;
        bus.mem_wdata = bus.host_wdata;
        bus.mem_we    = bus.host_we;
        state_nxt     = RESP;
      end
      RESP: begin
        bus.host_ack = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.io_we      = bus.io_req & bus.cpu_we;
  assign bus.cpu_di     = io_sel_q ? bus.io_rdata : bus.mem_rdata;
  assign bus.host_rdata = bus.host_ack ? bus.mem_rdata : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, directed scenarios, then random
// host and CPU traffic checked against a simple memory/PIA model.
module tb_mem_arbiter;

  localparam logic [15:0] IOB = 16'hD010;
  localparam int          GAP = 4;

  logic clk_dut = 1'b0;
  logic reset_n;
  always #5 clk_dut = ~clk_dut;

  mem_arbiter_if bus();

  mem_arbiter #(.IO_BASE(IOB), .HOST_GAP(GAP)) dut (
    .clk_dut (clk_dut),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // RAM with one-cycle read latency
  logic [7:0] ram [0:65535];
  always @(posedge clk_dut) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int cyc = 0;
  always @(posedge clk_dut) cyc <= cyc + 1;

  int io_we_cnt = 0;
  always @(negedge clk_dut) if (bus.io_we === 1'b1) io_we_cnt <= io_we_cnt + 1;

  int tests = 0;
  int fails = 0;

  logic [7:0]  rd;
  logic [7:0]  d;
  logic [7:0]  ref_mem [0:15];
  logic [15:0] addr;
  logic [15:0] prev_addr;
  bit          prev_ok;
  bit          wr;
  int          a1, a2, idx, last_ack, io_cnt0, lows, nacks;
  int          ackc [0:2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_io(input int a);
    return (a - int'(IOB)) >= 0 && (a - int'(IOB)) <= 3;
  endfunction

  // One host access; checks the two stolen cycles and returns data and ack cycle.
  task automatic host_xfer(input logic [15:0] a, input bit w, input logic [7:0] wd,
                           output logic [7:0] rdata, output int ack_cyc);
    int  nlow;
    bit  got;
    nlow = 0;
    got  = 0;
    rdata = 8'hxx;
    ack_cyc = -1;
    bus.host_addr  = a;
    bus.host_we    = w;
    bus.host_wdata = wd;
    bus.host_req   = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_dut);
      if (bus.cpu_rdy === 1'b0) begin
        chk("xfer_mem_we", bus.mem_we, (nlow == 0) ? w : 1'b0);
        if (nlow == 0) chk("xfer_mem_addr", bus.mem_addr, a);
        nlow++;
      end
      if (bus.host_ack === 1'b1) begin
        got = 1;
        rdata = bus.host_rdata;
        ack_cyc = cyc;
      end
    end
    @(posedge clk_dut); #1;
    bus.host_req = 1'b0;
    chk("xfer_ack_seen", got, 1'b1);
    chk("xfer_rdy_low_cycles", nlow, 2);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.cpu_addr   = 16'h0000;
    bus.cpu_do     = 8'h00;
    bus.cpu_we     = 1'b0;
    bus.rdy_in     = 1'b1;
    bus.cpu_halt   = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 16'h0000;
    bus.host_wdata = 8'h00;
    bus.io_rdata   = 8'h00;

    // Reset state
    #12;
    chk("rst_cpu_rdy", bus.cpu_rdy, 1'b1);
    chk("rst_host_ack", bus.host_ack, 1'b0);
    chk("rst_io_req", bus.io_req, 1'b0);
    bus.rdy_in = 1'b0;
    #1;
    chk("rst_cpu_rdy_follows", bus.cpu_rdy, 1'b0);
    bus.rdy_in = 1'b1;
    @(negedge clk_dut);
    reset_n = 1'b1;

    // CPU-only: write D8 to FF00, then read it back
    @(posedge clk_dut); #1;
    bus.cpu_addr = 16'hFF00; bus.cpu_do = 8'hD8; bus.cpu_we = 1'b1;
    @(posedge clk_dut); #1;
    bus.cpu_we = 1'b0;
    @(negedge clk_dut);
    chk("cpu_rd_mem_addr", bus.mem_addr, 16'hFF00);
    chk("cpu_rd_rdy", bus.cpu_rdy, 1'b1);
    @(negedge clk_dut);
    chk("cpu_rd_di", bus.cpu_di, 8'hD8);
    chk("cpu_rd_rdy2", bus.cpu_rdy, 1'b1);

    // CPU PIA write then PIA read
    @(posedge clk_dut); #1;
    bus.cpu_addr = 16'hD012; bus.cpu_do = 8'h8D; bus.cpu_we = 1'b1;
    @(negedge clk_dut);
    chk("pia_wr_io_req", bus.io_req, 1'b1);
    chk("pia_wr_io_we", bus.io_we, 1'b1);
    chk("pia_wr_mem_we", bus.mem_we, 1'b0);
    @(posedge clk_dut); #1;
    bus.cpu_addr = 16'hD011; bus.cpu_we = 1'b0; bus.io_rdata = 8'hA7;
    @(negedge clk_dut);
    chk("pia_rd_io_req", bus.io_req, 1'b1);
    chk("pia_rd_io_we", bus.io_we, 1'b0);
    @(posedge clk_dut); #1;
    bus.cpu_addr = 16'h0000;
    @(negedge clk_dut);
    chk("pia_rd_di", bus.cpu_di, 8'hA7);

    // Halted CPU: back-to-back host write/read, acks 3 cycles apart
    @(posedge clk_dut); #1;
    bus.cpu_halt = 1'b1;
    host_xfer(16'h0200, 1'b1, 8'h5A, rd, a1);
    host_xfer(16'h0200, 1'b0, 8'h00, rd, a2);
    chk("b2b_ack_spacing", a2 - a1, 3);
    chk("b2b_rdata", rd, 8'h5A);

    // Host write into the PIA window lands in RAM only
    io_cnt0 = io_we_cnt;
    host_xfer(16'hD013, 1'b1, 8'h3C, rd, a1);
    @(negedge clk_dut);
    chk("host_io_no_pia", io_we_cnt, io_cnt0);
    chk("host_io_ram", ram[16'hD013], 8'h3C);

    // Running CPU, request held: gap counter loaded with GAP, grant when it reads 0
    @(posedge clk_dut); #1;
    bus.cpu_halt = 1'b0;
    bus.host_addr = 16'h0200; bus.host_we = 1'b0; bus.host_req = 1'b1;
    lows = 0; nacks = 0;
    for (int i = 0; i < 80 && nacks < 3; i++) begin
      @(negedge clk_dut);
      if (bus.cpu_rdy === 1'b0) lows++;
      if (bus.host_ack === 1'b1) begin
        ackc[nacks] = cyc;
        nacks++;
      end
    end
    @(posedge clk_dut); #1;
    bus.host_req = 1'b0;
    chk("gap_acks", nacks, 3);
    chk("gap_rdy_low", lows, 6);
    chk("gap_spacing1", ackc[1] - ackc[0], GAP + 3);
    chk("gap_spacing2", ackc[2] - ackc[1], GAP + 3);

    // Same-cycle CPU write and host read of 0300
    repeat (8) @(posedge clk_dut);
    #1;
    bus.cpu_addr = 16'h0300; bus.cpu_do = 8'h11; bus.cpu_we = 1'b1;
    bus.host_addr = 16'h0300; bus.host_we = 1'b0; bus.host_req = 1'b1;
    @(negedge clk_dut);
    chk("same_cyc_mem_we", bus.mem_we, 1'b1);
    chk("same_cyc_rdy", bus.cpu_rdy, 1'b1);
    host_xfer(16'h0300, 1'b0, 8'h00, rd, a1);
    bus.cpu_we = 1'b0;
    chk("same_cyc_rdata", rd, 8'h11);

    // Reset during GRANT aborts the access; re-issue completes
    bus.cpu_halt = 1'b1; bus.cpu_addr = 16'h0000;
    bus.host_addr = 16'h0200; bus.host_we = 1'b0; bus.host_req = 1'b1;
    @(posedge clk_dut); #2;
    chk("abort_in_grant", bus.cpu_rdy, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("abort_rdy", bus.cpu_rdy, 1'b1);
    chk("abort_mem_addr", bus.mem_addr, 16'h0000);
    chk("abort_ack0", bus.host_ack, 1'b0);
    @(negedge clk_dut);
    @(negedge clk_dut);
    chk("abort_ack1", bus.host_ack, 1'b0);
    #1;
    reset_n = 1'b1;
    host_xfer(16'h0200, 1'b0, 8'h00, rd, a1);
    chk("abort_reissue_rdata", rd, 8'h5A);

    // Random host traffic, halted CPU; model is a plain array
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      host_xfer(16'h0600 + 16'(i), 1'b1, d, rd, a1);
      ref_mem[i] = d;
    end
    last_ack = -1;
    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(0, 15);
      wr  = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      host_xfer(16'h0600 + 16'(idx), wr, d, rd, a1);
      if (wr) ref_mem[idx] = d;
      else chk("rnd_host_rdata", rd, ref_mem[idx]);
      if (last_ack >= 0) chk("rnd_ack_spacing", a1 - last_ack, 3);
      last_ack = a1;
    end

    // Random CPU reads over RAM and the PIA window
    bus.cpu_halt = 1'b0;
    prev_ok = 0;
    prev_addr = 16'h0000;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk_dut); #1;
      if ($urandom_range(0, 2) == 0) addr = IOB + 16'($urandom_range(0, 3));
      else addr = 16'h0600 + 16'($urandom_range(0, 15));
      bus.cpu_addr = addr;
      bus.io_rdata = 8'($urandom);
      @(negedge clk_dut);
      chk("rnd_cpu_io_req", bus.io_req, in_io(int'(addr)));
      if (prev_ok)
        chk("rnd_cpu_di", bus.cpu_di,
            in_io(int'(prev_addr)) ? bus.io_rdata : ref_mem[prev_addr[3:0]]);
      prev_addr = addr;
      prev_ok = 1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
